// File: rtl/counter_checker.sv
// Receive-side monitor for a wrap-around counter stream: locks onto the sequence, then flags and tallies breaks.
// Optional CNT_CHK_ZERO_RESYNC_EN: while locked, an unexpected 0 is accepted as a source restart.
module counter_checker #(
  parameter int WIDTH       = 8,
  parameter int LOCK_COUNT  = 4,
  parameter int UNLOCK_ERRS = 2,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cmpt_in,
  input  logic             valid_in,
  input  logic             clr_err,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] expected
);

  localparam logic [3:0] LockTarget   = 4'(LOCK_COUNT);
  localparam logic [3:0] UnlockTarget = 4'(UNLOCK_ERRS);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [3:0]       r_matchCnt;
  logic [3:0]       w_matchCntNext;
  logic [3:0]       r_consecErr;
  logic [3:0]       w_consecErrNext;
  logic [WIDTH-1:0] w_expectedNext;
  logic             w_match;
  logic             w_zeroResync;
  logic             w_errHit;

  assign w_match = (cmpt_in == expected);

`ifdef CNT_CHK_ZERO_RESYNC_EN
  assign w_zeroResync = (cmpt_in == '0) && !w_match;
`else
  assign w_zeroResync = 1'b0;
`endif

  // Every valid beat re-seeds the expectation, even a mismatching one.
  always_comb begin
    w_stateNext     = r_state;
    w_matchCntNext  = r_matchCnt;
    w_consecErrNext = r_consecErr;
    w_expectedNext  = expected;
    w_errHit        = 1'b0;
    if (valid_in) begin
      w_expectedNext = cmpt_in + 1'b1;
      case (r_state)
        HUNT: begin
          w_matchCntNext  = 4'd1;
          w_consecErrNext = 4'd0;
          w_stateNext     = SYNC;
        end
        SYNC: begin
          if (!w_match) begin
            w_matchCntNext = 4'd1;
          end else begin
            w_matchCntNext = r_matchCnt + 4'd1;
            if (r_matchCnt + 4'd1 == LockTarget) begin
              w_consecErrNext = 4'd0;
              w_stateNext     = LOCKED;
            end
          end
        end
        LOCKED: begin
          if (w_match || w_zeroResync) begin
            w_consecErrNext = 4'd0;
          end else begin
            w_errHit = 1'b1;
            if (r_consecErr + 4'd1 == UnlockTarget) begin
              w_consecErrNext = 4'd0;
              w_matchCntNext  = 4'd0;
              w_stateNext     = HUNT;
            end else begin
              w_consecErrNext = r_consecErr + 4'd1;
            end
          end
        end
        default: begin
          w_stateNext    = HUNT;
          w_matchCntNext = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= HUNT;
      r_matchCnt  <= 4'd0;
      r_consecErr <= 4'd0;
      locked      <= 1'b0;
      err_pulse   <= 1'b0;
      expected    <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_matchCnt  <= w_matchCntNext;
      r_consecErr <= w_consecErrNext;
      locked      <= (w_stateNext == LOCKED);
      err_pulse   <= w_errHit;
      expected    <= w_expectedNext;
    end
  end

  // A clear on the same beat as an error wins over the increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (clr_err) begin
      err_count <= '0;
    end else if (w_errHit && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_counter_checker.sv
// Self-checking bench for counter_checker: vector table, hand-written corner sequences, and a randomized run
// against a behavioural model (a second instance with a narrow error counter exercises saturation).
module tb_counter_checker;

  localparam int W   = 8;
  localparam int LC  = 4;
  localparam int UE  = 2;
  localparam int EW  = 16;
  localparam int EWS = 3;

`ifdef CNT_CHK_ZERO_RESYNC_EN
  localparam bit ZeroResync = 1'b1;
`else
  localparam bit ZeroResync = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   cmpt_in;
  logic           valid_in;
  logic           clr_err;
  logic           locked, err_pulse;
  logic [EW-1:0]  err_count;
  logic [W-1:0]   expected;
  logic           locked2, errPulse2;
  logic [EWS-1:0] errCount2;
  logic [W-1:0]   expected2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_checker #(.WIDTH(W), .LOCK_COUNT(LC), .UNLOCK_ERRS(UE), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .cmpt_in(cmpt_in), .valid_in(valid_in), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .expected(expected)
  );

  counter_checker #(.WIDTH(W), .LOCK_COUNT(LC), .UNLOCK_ERRS(UE), .ERR_W(EWS)) dutSmall (
    .clk(clk), .rst(rst), .cmpt_in(cmpt_in), .valid_in(valid_in), .clr_err(clr_err),
    .locked(locked2), .err_pulse(errPulse2), .err_count(errCount2), .expected(expected2)
  );

  typedef struct {
    logic         valid;
    logic [W-1:0] data;
    logic         clr;
    logic         expLocked;
    logic         expPulse;
    logic [EW-1:0] expCount;
    logic [W-1:0] expExpected;
  } vec_t;

  vec_t vq[$];

  function automatic void addVec(logic v, int d, logic c, logic l, logic p, int cnt, int e);
    vec_t x;
    x.valid = v; x.data = W'(d); x.clr = c;
    x.expLocked = l; x.expPulse = p; x.expCount = EW'(cnt); x.expExpected = W'(e);
    vq.push_back(x);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
    end
  endtask

  task automatic checkAll(input string tag, input logic l, input logic p, input int c, input int e);
    checkOutput({tag, ".locked"}, 32'(locked), 32'(l));
    checkOutput({tag, ".err_pulse"}, 32'(err_pulse), 32'(p));
    checkOutput({tag, ".err_count"}, 32'(err_count), c);
    checkOutput({tag, ".expected"}, 32'(expected), e);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic v, input int d, input logic c);
    @(negedge clk);
    valid_in = v;
    cmpt_in  = W'(d);
    clr_err  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    valid_in = 1'b0;
    clr_err  = 1'b0;
    cmpt_in  = '0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic lockOn(input int start);
    for (int i = 0; i < LC; i++) applyStimulus(1'b1, (start + i) % 256, 1'b0);
  endtask

  // Behavioural reference state for the randomized run
  bit mSeeded, mLocked, mPulse;
  int mRun, mMiss, mExp, mCount, mCountSmall;

  function automatic void modelReset();
    mSeeded = 0; mLocked = 0; mPulse = 0;
    mRun = 0; mMiss = 0; mExp = 0; mCount = 0; mCountSmall = 0;
  endfunction

  function automatic void modelBeat(bit v, int d, bit c);
    mPulse = 0;
    if (v) begin
      if (!mLocked) begin
        if (!mSeeded) begin
          mSeeded = 1;
          mRun = 1;
        end else if (d == mExp) begin
          mRun++;
        end else begin
          mRun = 1;
        end
        if (mRun >= LC) begin
          mLocked = 1;
          mMiss = 0;
        end
      end else if (d == mExp || (ZeroResync && d == 0)) begin
        mMiss = 0;
      end else begin
        mPulse = 1;
        if (mCount < (1 << EW) - 1) mCount++;
        if (mCountSmall < (1 << EWS) - 1) mCountSmall++;
        mMiss++;
        if (mMiss >= UE) begin
          mLocked = 0;
          mSeeded = 0;
          mMiss = 0;
        end
      end
      mExp = (d + 1) % 256;
    end
    if (c) begin
      mCount = 0;
      mCountSmall = 0;
    end
  endfunction

  initial begin
    rst = 1'b1; valid_in = 1'b0; clr_err = 1'b0; cmpt_in = '0;
    #2;
    checkAll("reset", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    addVec(1, 10, 0, 0, 0, 0, 11);
    addVec(1, 11, 0, 0, 0, 0, 12);
    addVec(1, 12, 0, 0, 0, 0, 13);
    addVec(1, 13, 0, 1, 0, 0, 14);
    addVec(0, 99, 0, 1, 0, 0, 14);
    addVec(1, 14, 0, 1, 0, 0, 15);
    addVec(1, 20, 0, 1, 1, 1, 21);
    addVec(1, 21, 0, 1, 0, 1, 22);
    addVec(1, 40, 0, 1, 1, 2, 41);
    addVec(1, 41, 0, 1, 0, 2, 42);
    addVec(0,  0, 1, 1, 0, 0, 42);
    addVec(1, 42, 0, 1, 0, 0, 43);
    addVec(1,  9, 0, 1, 1, 1, 10);
    addVec(1, 30, 0, 0, 1, 2, 31);
    addVec(1, 31, 0, 0, 0, 2, 32);
    addVec(1, 32, 0, 0, 0, 2, 33);
    addVec(1, 50, 0, 0, 0, 2, 51);
    addVec(0,  7, 0, 0, 0, 2, 51);
    addVec(1, 51, 0, 0, 0, 2, 52);
    addVec(1, 52, 0, 0, 0, 2, 53);
    addVec(1, 53, 0, 1, 0, 2, 54);
    addVec(1, 77, 1, 1, 1, 0, 78);
    addVec(1, 78, 0, 1, 0, 0, 79);
    addVec(0,  0, 0, 1, 0, 0, 79);
    foreach (vq[i]) begin
      applyStimulus(vq[i].valid, int'(vq[i].data), vq[i].clr);
      checkAll($sformatf("vec%0d", i), vq[i].expLocked, vq[i].expPulse,
               int'(vq[i].expCount), int'(vq[i].expExpected));
    end

    // Wrap from 255 to 0 is in sequence
    doReset();
    lockOn(250);
    checkAll("wrapLock", 1'b1, 1'b0, 0, 254);
    applyStimulus(1'b1, 254, 1'b0);
    applyStimulus(1'b1, 255, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
    checkAll("wrapZero", 1'b1, 1'b0, 0, 1);
    applyStimulus(1'b1, 1, 1'b0);
    checkAll("wrapEnd", 1'b1, 1'b0, 0, 2);

    // Unexpected zero while locked
    doReset();
    lockOn(96);
    applyStimulus(1'b1, 100, 1'b0);
    applyStimulus(1'b1, 0, 1'b0);
`ifdef CNT_CHK_ZERO_RESYNC_EN
    checkAll("zeroResync", 1'b1, 1'b0, 0, 1);
`else
    checkAll("zeroMismatch", 1'b1, 1'b1, 1, 1);
`endif

    // Asynchronous reset mid-stream clears lock and tally without a clock edge
    doReset();
    lockOn(10);
    applyStimulus(1'b1, 99, 1'b0);
    checkAll("preAsync", 1'b1, 1'b1, 1, 100);
    #2;
    rst = 1'b1;
    #1;
    checkAll("asyncReset", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i < LC; i++) begin
      applyStimulus(1'b1, i, 1'b0);
      checkOutput($sformatf("relockWait%0d", i), 32'(locked), 32'd0);
    end
    applyStimulus(1'b1, LC, 1'b0);
    checkOutput("relockDone", 32'(locked), 32'd1);

    // Randomized run against the behavioural model
    doReset();
    modelReset();
    for (int n = 0; n < 3000; n++) begin
      int r, d;
      bit v, c;
      v = ($urandom_range(0, 9) < 8);
      c = ($urandom_range(0, 19) == 0);
      r = int'($urandom_range(0, 99));
      if (r < 85)      d = mExp;
      else if (r < 90) d = 0;
      else             d = int'($urandom_range(0, 255));
      applyStimulus(v, d, c);
      modelBeat(v, d, c);
      checkAll($sformatf("rand%0d", n), mLocked, mPulse, mCount, mExp);
      checkOutput($sformatf("rand%0d.smallCount", n), 32'(errCount2), mCountSmall);
      checkOutput($sformatf("rand%0d.smallLocked", n), 32'(locked2), 32'(mLocked));
      checkOutput($sformatf("rand%0d.smallPulse", n), 32'(errPulse2), 32'(mPulse));
      checkOutput($sformatf("rand%0d.smallExpected", n), 32'(expected2), mExp);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_checker.md
Name: counter_checker

Overview:
- Receive-side monitor for the free-running wrap-around counter stream used across the design (0,1,...,2^W-1,0,...).
- Samples an incoming count bus on a qualifier and locks onto the sequence.
- Once locked, flags every break in the sequence and keeps a saturating error tally.
- Serves as the reader end of the counter link for bring-up and on-chip self-test.

Parameters:
- WIDTH, 8, width of the monitored count bus.
- LOCK_COUNT, 4, consecutive in-sequence samples, first included, required to declare lock (legal range 2..15).
- UNLOCK_ERRS, 2, consecutive mismatches while locked that drop lock (legal range 1..15).
- ERR_W, 16, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmpt_in  input  WIDTH  count value under test.
- valid_in  input  1  cmpt_in is sampled on each rising clk edge where this is high.
- clr_err  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED state.
- err_pulse  output  1  one-cycle pulse per mismatch detected while locked.
- err_count  output  ERR_W  saturating count of mismatches while locked.
- expected  output  WIDTH  next value the checker expects.

Behaviour:
- Reset (async assert, applied immediately):
  - State = HUNT.
  - locked = 0, err_pulse = 0, err_count = 0, expected = 0.
  - Internal match and error counters = 0.
- All outputs are registered and update on the edge that samples the valid_in beat (1-cycle latency). With valid_in low, no state change, and err_pulse = 0.
- expected always updates to (sample + 1) mod 2^WIDTH on every valid beat, in every state. Wrap from 2^WIDTH-1 to 0 is in-sequence.
- HUNT:
  - First valid beat sets match_cnt = 1 and moves to SYNC.
- SYNC:
  - Match (sample == expected): match_cnt++. When match_cnt reaches LOCK_COUNT, move to LOCKED and assert locked.
  - Mismatch: match_cnt = 1, stay in SYNC.
  - No errors are counted or pulsed in SYNC.
- LOCKED:
  - Match: consec_err = 0.
  - Mismatch:
    - err_pulse = 1 for one cycle.
    - err_count increments, saturating at 2^ERR_W-1.
    - consec_err++.
    - If consec_err reaches UNLOCK_ERRS: move to HUNT, locked = 0, match_cnt = 0.
    - The mismatching beat still re-seeds expected.
- clr_err:
  - Sets err_count = 0 on the next edge.
  - If asserted on the same beat as an error, clear wins: err_count = 0, err_pulse still fires.
  - Does not affect state or lock.
- Back-to-back valid beats are supported at full rate. Gaps of any length between beats are legal and not errors.
- Reset asserted mid-sequence discards lock and tally. Relock requires LOCK_COUNT beats after release.

Optional Feature:
- Macro: CNT_CHK_ZERO_RESYNC_EN.
- Defined: in LOCKED, a sample of 0 that mismatches expected is treated as a legal source reset. No err_pulse, no err_count change, consec_err = 0, lock held, expected = 1.
- Undefined: a 0 sample is an ordinary value, and an unexpected 0 is a mismatch.
- SYNC and HUNT behaviour is identical either way.

Test Plan:
- Reset, then feed 10,11,12,13 on consecutive valid beats -> locked = 1 on the edge sampling 13, expected = 14, err_count = 0.
- Locked, feed 254,255,0,1 -> no err_pulse, locked stays 1, expected = 2.
- Locked, sequence 20,21,40,41 -> single err_pulse on the 40 beat, err_count = 1, locked stays 1 (UNLOCK_ERRS = 2).
- Locked, feed 5,9,30 where 6 is expected -> pulses on 9 and 30, err_count += 2, locked = 0 after 30. Then 31,32,33,34 -> relock.
- Locked, feed 100 then 0:
  - Macro undefined -> err_pulse on the 0 beat, err_count = 1.
  - Macro defined -> no pulse, err_count = 0, expected = 1.
- Error and clr_err on the same beat -> err_count = 0, err_pulse = 1. Assert rst asynchronously mid-stream -> locked = 0 immediately, without waiting for a clk edge.
